// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Package : riscv_ctrl_pkg
// Purpose : Shared state, opcode and mux encodings for the multi-cycle
//           RV32I controller and its ALU decoder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_JALR      = 4'd11,
        S_LINK      = 4'd12,
        S_LUI       = 4'd13,
        S_TRAP      = 4'd14
    } state_e;

    typedef enum logic [1:0] {
        ALU_CLS_R  = 2'd0,
        ALU_CLS_I  = 2'd1,
        ALU_CLS_BR = 2'd2
    } alu_cls_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format needed while DECODE forms the branch/jal target.
    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_of = IMM_S;
            OP_BRANCH: imm_of = IMM_B;
            OP_LUI:    imm_of = IMM_U;
            OP_JAL:    imm_of = IMM_J;
            default:   imm_of = IMM_I;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Interface : multicycle_controller_if
// Purpose   : Control/status bundle between the controller and the datapath.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface multicycle_controller_if;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero;
    logic       sign;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_func;
    logic [2:0] imm_src;
    logic       illegal;

    modport master (
        input  opcode, func3, func7, zero, sign, mem_ready,
        output pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_func, imm_src, illegal
    );

    modport slave (
        output opcode, func3, func7, zero, sign, mem_ready,
        input  pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_func, imm_src, illegal
    );

endinterface

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// Module  : alu_decoder
// Purpose : Maps instruction class + func3/func7 onto an alu_func code and
//           flags combinations the core does not implement.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_UNSIGNED_BR = 1'b1
) (
    input  alu_cls_e   cls_i,
    input  logic [2:0] func3_i,
    input  logic [6:0] func7_i,
    output logic [2:0] alu_func_o,
    output logic       unsupported_o
);

    always_comb begin
        alu_func_o    = ALU_ADD;
        unsupported_o = 1'b0;
        case (cls_i)
            ALU_CLS_R: begin
                if (func7_i == 7'b0000000) begin
                    case (func3_i)
                        3'b000:  alu_func_o = ALU_ADD;
                        3'b111:  alu_func_o = ALU_AND;
                        3'b110:  alu_func_o = ALU_OR;
                        3'b100:  alu_func_o = ALU_XOR;
                        3'b010:  alu_func_o = ALU_SLT;
                        3'b011:  alu_func_o = ALU_SLTU;
                        default: unsupported_o = 1'b1;
                    endcase
                end else if (func7_i == 7'b0100000 && func3_i == 3'b000) begin
                    alu_func_o = ALU_SUB;
                end else begin
                    unsupported_o = 1'b1;
                end
            end
            ALU_CLS_I: begin
                case (func3_i)
                    3'b000:  alu_func_o = ALU_ADD;
                    3'b110:  alu_func_o = ALU_OR;
                    3'b100:  alu_func_o = ALU_XOR;
                    3'b010:  alu_func_o = ALU_SLT;
                    3'b011:  alu_func_o = ALU_SLTU;
                    default: unsupported_o = 1'b1;
                endcase
            end
            ALU_CLS_BR: begin
                // Unsigned branches compare with sltu; signed ones inspect sub.
                case (func3_i)
                    3'b000, 3'b001, 3'b100, 3'b101: alu_func_o = ALU_SUB;
                    3'b110, 3'b111: begin
                        if (SUPPORT_UNSIGNED_BR) begin
                            alu_func_o = ALU_SLTU;
                        end else begin
                            unsupported_o = 1'b1;
                        end
                    end
                    default: unsupported_o = 1'b1;
                endcase
            end
            default: unsupported_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module  : multicycle_controller
// Purpose : Moore FSM sequencing fetch/decode/execute/memory/writeback for a
//           shared-memory multi-cycle RV32I datapath.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT            = 1'b1,
    parameter bit SUPPORT_UNSIGNED_BR = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    state_e     state_q;
    state_e     state_d;

    logic       ready;
    alu_cls_e   alu_cls;
    logic [2:0] dec_func;
    logic       dec_unsup;
    logic       br_taken;

    logic       pc_write;
    logic       adr_src;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_func;
    logic [2:0] imm_src;
    logic       illegal;

    assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

    assign alu_cls = (state_q == S_EXEC_I) ? ALU_CLS_I :
                     (state_q == S_BRANCH) ? ALU_CLS_BR : ALU_CLS_R;

    alu_decoder #(
        .SUPPORT_UNSIGNED_BR (SUPPORT_UNSIGNED_BR)
    ) u_alu_decoder (
        .cls_i         (alu_cls),
        .func3_i       (bus.func3),
        .func7_i       (bus.func7),
        .alu_func_o    (dec_func),
        .unsupported_o (dec_unsup)
    );

    // Flags reflect sub for signed forms and sltu for unsigned forms.
    always_comb begin
        case (bus.func3)
            3'b000:  br_taken = bus.zero;
            3'b001:  br_taken = ~bus.zero;
            3'b100:  br_taken = bus.sign;
            3'b101:  br_taken = ~bus.sign;
            3'b110:  br_taken = ~bus.zero;
            3'b111:  br_taken = bus.zero;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_func   = ALU_ADD;
        imm_src    = IMM_I;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = ready;
                pc_write   = ready;
                if (ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = imm_of(bus.opcode);
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = (bus.func3 == 3'b000) ? S_JALR : S_TRAP;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                if (bus.func3 == 3'b010) begin
                    state_d = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                result_src = RES_MDR;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_func  = dec_func;
                state_d   = dec_unsup ? S_TRAP : S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_func  = dec_func;
                state_d   = dec_unsup ? S_TRAP : S_ALU_WB;
            end
            S_ALU_WB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                result_src = RES_ALUOUT;
                alu_func   = dec_func;
                pc_write   = br_taken & ~dec_unsup;
                state_d    = dec_unsup ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_I;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset silences every strobe, including the sticky trap flag.
        if (rst) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_func   = 3'b000;
            imm_src    = 3'b000;
            illegal    = 1'b0;
        end
    end

    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.reg_write  = reg_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_func   = alu_func;
    assign bus.imm_src    = imm_src;
    assign bus.illegal    = illegal;

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle RV32I control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and writeback over several clocks for a shared-memory datapath (single ALU, IR/oldPC/A/B/ALUOut/MDR registers).
- Successor to the single-cycle controller:
  - adds a memory ready handshake, unsigned branches, xor/xori decode and a sticky illegal-instruction trap.
  - keeps the same alu_func encoding.

Parameters:
MEM_WAIT, 1, 1: FETCH/MEM_READ/MEM_WRITE hold until mem_ready; 0: mem_ready ignored, treated as 1.
SUPPORT_UNSIGNED_BR, 1, 1: bltu/bgeu decoded; 0: they trap as illegal.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
opcode  in  7  IR[6:0]
func3  in  3  IR[14:12]
func7  in  7  IR[31:25]
zero  in  1  ALU result == 0
sign  in  1  ALU result[31]
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  load PC from result mux
adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load IR and oldPC
reg_write  out  1  register file write
result_src  out  2  00 ALUOut, 01 MDR, 10 ALU result, 11 immediate
alu_src_a  out  2  00 PC, 01 oldPC, 10 A(rs1)
alu_src_b  out  2  00 B(rs2), 01 imm, 10 constant 4
alu_func  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu
imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
illegal  out  1  sticky trap flag

Behaviour:
- Reset:
  - State register resets synchronously to FETCH.
  - While rst = 1, every output is forced to 0 (including illegal).
- Outputs are decoded from the current state. Exception: pc_write in BRANCH also depends on zero/sign/func3.
- Unlisted outputs in any state are 0.

State outputs and transitions:
- FETCH:
  - mem_read=1, adr_src=0, a=00, b=10, alu add, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while !mem_ready; otherwise goes to DECODE.
- DECODE:
  - a=01, b=01, alu add (ALUOut <= branch/jal target); imm_src from opcode.
  - Next state by opcode:
    - 0000011 → MEM_ADR
    - 0100011 → MEM_ADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 with func3=000 → JALR
    - 0110111 → LUI
    - anything else → TRAP
- MEM_ADR:
  - a=10, b=01, alu add; imm_src I for lw, S for sw.
  - lw (func3 010) → MEM_READ; sw (func3 010) → MEM_WRITE; other func3 → TRAP.
- MEM_READ: mem_read=1, adr_src=1; → MEM_WB when mem_ready.
- MEM_WB: result_src=01, reg_write=1; → FETCH.
- MEM_WRITE: mem_write=1, adr_src=1; held until mem_ready; → FETCH.
- EXEC_R:
  - a=10, b=00; alu_func from func7/func3: add, sub(0100000/000), and, or, xor, slt, sltu.
  - Unsupported combination → TRAP; else → ALU_WB.
- EXEC_I:
  - a=10, b=01, imm I; addi/ori/xori/slti/sltiu mapped the same as R-type.
  - Any other func3 → TRAP; else → ALU_WB.
- ALU_WB: result_src=00, reg_write=1; → FETCH.
- BRANCH:
  - a=10, b=00, result_src=00 (target in ALUOut).
  - alu sub for beq/bne/blt/bge; sltu for bltu/bgeu.
  - pc_write (taken) per func3:
    - beq: zero
    - bne: !zero
    - blt: sign
    - bge: !sign
    - bltu: !zero
    - bgeu: zero
  - func3 010/011 → TRAP; else → FETCH.
- JAL: pc_write=1, result_src=00; a=01, b=10, add; → ALU_WB.
- JALR: a=10, b=01, imm I, add, result_src=10, pc_write=1; → LINK.
- LINK: a=01, b=10, add; → ALU_WB.
- LUI: imm_src=011, result_src=11, reg_write=1; → FETCH.
- TRAP:
  - illegal=1; pc_write, reg_write and memory requests all 0.
  - Remains in TRAP until rst.

Latency:
- Cycles with mem_ready=1:
  - lw 5
  - sw 4
  - R/I 4
  - branch 3
  - jal 4
  - jalr 5
  - lui 3
- Each wait cycle adds 1.

Boundary conditions:
- Reset mid-instruction: aborts it; the next cycle is FETCH with no write strobes.
- mem_ready high outside FETCH/MEM_READ/MEM_WRITE is ignored.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - alu_func codes
  - imm_src codes
  - result/alu_src mux codes
- Sub-module alu_decoder: (opcode class, func3, func7) → alu_func + unsupported flag. Used by EXEC_R, EXEC_I and BRANCH.

Test Plan:
- add x3,x1,x2 with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; alu_func=000; reg_write=1 only in cycle 4.
- lw with mem_ready low 2 cycles in FETCH and 1 in MEM_READ → 8 cycles total; result_src=01 in MEM_WB; ir_write only on the ready cycle.
- bltu with zero=0 → pc_write=1, alu_func=110; with zero=1 → pc_write=0; instruction completes in 3 cycles.
- jalr → pc_write in JALR with result_src=10; reg_write in ALU_WB after LINK (a=01, b=10).
- opcode 0001111 → TRAP after DECODE, illegal=1 held 10 cycles; rst=1 → illegal=0, FETCH next cycle.
- SUPPORT_UNSIGNED_BR=0 with bgeu → TRAP; MEM_WAIT=0 with mem_ready tied 0 → lw completes in 5 cycles.
